// File: rtl/par_link_tx_arb_if.sv
// par_link_tx_arb_if: channel write side and valid/ready link side of the
// multi-channel parallel-link transmitter.
// Optional feature macro: TX_PARITY_EN adds parallel_parity_out.
interface par_link_tx_arb_if #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
);
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [NUM_CH-1:0]        wr_en;
  logic [NUM_CH-1:0]        fifo_full;
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH-1:0]        overflow;
  logic [DATA_W-1:0]        parallel_data_out;
  logic [CH_W-1:0]          parallel_chan_out;
  logic                     parallel_valid_out;
  logic                     parallel_ready_in;
`ifdef TX_PARITY_EN
  logic                     parallel_parity_out;

  modport master (
    input  data_in, wr_en, parallel_ready_in,
    output fifo_full, fifo_empty, overflow,
    output parallel_data_out, parallel_chan_out, parallel_valid_out,
    output parallel_parity_out
  );

  modport slave (
    output data_in, wr_en, parallel_ready_in,
    input  fifo_full, fifo_empty, overflow,
    input  parallel_data_out, parallel_chan_out, parallel_valid_out,
    input  parallel_parity_out
  );
`else
  modport master (
    input  data_in, wr_en, parallel_ready_in,
    output fifo_full, fifo_empty, overflow,
    output parallel_data_out, parallel_chan_out, parallel_valid_out
  );

  modport slave (
    output data_in, wr_en, parallel_ready_in,
    input  fifo_full, fifo_empty, overflow,
    input  parallel_data_out, parallel_chan_out, parallel_valid_out
  );
`endif
endinterface

// File: rtl/par_link_tx_arb.sv
// par_link_tx_arb: NUM_CH input FIFOs, round-robin arbiter and a single
// holding register driving the valid/ready parallel link in clk_tx.
// Optional feature macro: TX_PARITY_EN registers even parity over
// {channel, data} alongside the held word.
module par_link_tx_arb #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int NUM_CH = 4,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input logic               clk_tx,
  input logic               rst_tx_n,
  par_link_tx_arb_if.master link
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  logic [DATA_W-1:0] mem  [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wptr [NUM_CH];
  logic [PTR_W-1:0]  rptr [NUM_CH];
  logic [CNT_W-1:0]  cnt  [NUM_CH];

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] ovf_q;
  logic [CH_W-1:0]   last_grant;
  logic [CH_W-1:0]   grant;
  logic              any_ne;
  logic              load;
  logic [DATA_W-1:0] rd_data;

  state_t            state;
  logic              vld_p1;
  logic [DATA_W-1:0] data_p1;
  logic [CH_W-1:0]   chan_p1;
`ifdef TX_PARITY_EN
  logic              par_p1;

  function automatic logic even_parity(input logic [CH_W-1:0] ch,
                                       input logic [DATA_W-1:0] d);
    return ^{ch, d};
  endfunction
`endif

  // Channel status from registered counts; a full FIFO refuses the write even if popped this cycle
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]  = (cnt[c] == CNT_FULL);
      empty[c] = (cnt[c] == '0);
      push[c]  = link.wr_en[c] && !full[c];
    end
  end

  // Round-robin search over non-empty channels starting after last_grant
  always_comb begin
    int              idx;
    logic [CH_W-1:0] cand;
    logic            found;
    idx   = 0;
    cand  = '0;
    found = 1'b0;
    grant = last_grant;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      cand = CH_W'(idx);
      if (!found && !empty[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  assign any_ne  = |(~empty);
  assign load    = any_ne && ((state == IDLE) || link.parallel_ready_in);
  assign pop     = load ? (NUM_CH'(1) << grant) : '0;
  assign rd_data = mem[grant][rptr[grant]];

  // Stage p0: FIFO pointers, occupancy counts and sticky overflow flags
  always_ff @(posedge clk_tx) begin
    if (!rst_tx_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wptr[c] <= '0;
        rptr[c] <= '0;
        cnt[c]  <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c]) wptr[c] <= wptr[c] + PTR_W'(1);
        if (pop[c])  rptr[c] <= rptr[c] + PTR_W'(1);
        case ({push[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + CNT_W'(1);
          2'b01:   cnt[c] <= cnt[c] - CNT_W'(1);
          default: cnt[c] <= cnt[c];
        endcase
        if (link.wr_en[c] && full[c]) ovf_q[c] <= 1'b1;
      end
    end
  end

  // Stage p0: FIFO storage, data only, never reset
  always_ff @(posedge clk_tx) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wptr[c]] <= link.data_in[c*DATA_W +: DATA_W];
    end
  end

  // Stage p1: holding register FSM; loads the granted word and holds it until accepted
  always_ff @(posedge clk_tx) begin
    if (!rst_tx_n) begin
      state      <= IDLE;
      vld_p1     <= 1'b0;
      data_p1    <= '0;
      chan_p1    <= '0;
      last_grant <= LAST_CH;
`ifdef TX_PARITY_EN
      par_p1     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            state      <= SEND;
            vld_p1     <= 1'b1;
            data_p1    <= rd_data;
            chan_p1    <= grant;
            last_grant <= grant;
`ifdef TX_PARITY_EN
            par_p1     <= even_parity(grant, rd_data);
`endif
          end
        end
        SEND: begin
          if (link.parallel_ready_in) begin
            if (load) begin
              data_p1    <= rd_data;
              chan_p1    <= grant;
              last_grant <= grant;
`ifdef TX_PARITY_EN
              par_p1     <= even_parity(grant, rd_data);
`endif
            end else begin
              state  <= IDLE;
              vld_p1 <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          vld_p1 <= 1'b0;
        end
      endcase
    end
  end

  assign link.fifo_full          = full;
  assign link.fifo_empty         = empty;
  assign link.overflow           = ovf_q;
  assign link.parallel_valid_out = vld_p1;
  assign link.parallel_data_out  = data_p1;
  assign link.parallel_chan_out  = chan_p1;
`ifdef TX_PARITY_EN
  assign link.parallel_parity_out = par_p1;
`endif

endmodule

// File: tb/tb_par_link_tx_arb.sv
// tb_par_link_tx_arb: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
// Optional feature macro: TX_PARITY_EN enables the parity checks.
module tb_par_link_tx_arb;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 8;
  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  logic clk_tx = 1'b0;
  logic rst_tx_n;

  par_link_tx_arb_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W)) lk ();

  par_link_tx_arb #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH), .CH_W(CH_W)
  ) dut (
    .clk_tx  (clk_tx),
    .rst_tx_n(rst_tx_n),
    .link    (lk)
  );

  always #5 clk_tx = ~clk_tx;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;
  int cyc = 0;

  // reference model state
  logic [DATA_W-1:0] mq [NUM_CH][$];
  bit                m_valid = 1'b0;
  logic [DATA_W-1:0] m_data = '0;
  int                m_chan = 0;
  int                m_lg = NUM_CH - 1;
  logic [NUM_CH-1:0] m_ovf = '0;

  // handshake log taken from the link
  int                hs_chan [$];
  logic [DATA_W-1:0] hs_data [$];
  int                hs_cyc  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_word(input int c, input logic [DATA_W-1:0] v);
    lk.data_in[c*DATA_W +: DATA_W] = v;
  endtask

  // model advances on every rising edge from the inputs presented before it
  always @(posedge clk_tx) begin : model
    int sz [NUM_CH];
    int g;
    bit found;
    if (rst_tx_n && lk.parallel_valid_out && lk.parallel_ready_in) begin
      hs_chan.push_back(int'(lk.parallel_chan_out));
      hs_data.push_back(lk.parallel_data_out);
      hs_cyc.push_back(cyc);
    end
    cyc++;
    if (!rst_tx_n) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_lg    = NUM_CH - 1;
      m_ovf   = '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) sz[c] = mq[c].size();
      if (!m_valid || lk.parallel_ready_in) begin
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
          g = (m_lg + i) % NUM_CH;
          if (!found && sz[g] > 0) begin
            found  = 1'b1;
            m_chan = g;
          end
        end
        if (found) begin
          m_data  = mq[m_chan].pop_front();
          m_valid = 1'b1;
          m_lg    = m_chan;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (lk.wr_en[c]) begin
          if (sz[c] == DEPTH) m_ovf[c] = 1'b1;
          else mq[c].push_back(lk.data_in[c*DATA_W +: DATA_W]);
        end
      end
    end
  end

  // per-cycle comparison against the model, away from the active edge
  always @(negedge clk_tx) begin : compare
    logic [NUM_CH-1:0] e_full;
    logic [NUM_CH-1:0] e_empty;
    if (cmp_en) begin
      for (int c = 0; c < NUM_CH; c++) begin
        e_full[c]  = (mq[c].size() == DEPTH);
        e_empty[c] = (mq[c].size() == 0);
      end
      chk("m_valid", lk.parallel_valid_out, m_valid);
      if (m_valid) begin
        chk("m_data", lk.parallel_data_out, m_data);
        chk("m_chan", lk.parallel_chan_out, m_chan);
`ifdef TX_PARITY_EN
        chk("m_parity", lk.parallel_parity_out, ^{m_chan[CH_W-1:0], m_data});
`endif
      end
      chk("m_full", lk.fifo_full, e_full);
      chk("m_empty", lk.fifo_empty, e_empty);
      chk("m_overflow", lk.overflow, m_ovf);
    end
  end

  task automatic do_reset();
    @(negedge clk_tx);
    rst_tx_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      lk.wr_en = (i % 2 == 0) ? 4'hF : 4'h0;
      for (int c = 0; c < NUM_CH; c++) set_word(c, 16'hDE00 + 16'(c));
      @(negedge clk_tx);
    end
    rst_tx_n = 1'b1;
    lk.wr_en = '0;
    lk.parallel_ready_in = 1'b1;
    chk("rst_valid", lk.parallel_valid_out, 0);
    chk("rst_data", lk.parallel_data_out, 0);
    chk("rst_chan", lk.parallel_chan_out, 0);
    chk("rst_empty", lk.fifo_empty, 4'hF);
    chk("rst_full", lk.fifo_full, 4'h0);
    chk("rst_overflow", lk.overflow, 4'h0);
`ifdef TX_PARITY_EN
    chk("rst_parity", lk.parallel_parity_out, 0);
`endif
    @(negedge clk_tx);
    @(negedge clk_tx);
    chk("rst_nostore_valid", lk.parallel_valid_out, 0);
    chk("rst_nostore_empty", lk.fifo_empty, 4'hF);
  endtask

  task automatic wait_hs(input int n, input int budget);
    int k;
    k = 0;
    while (hs_chan.size() < n && k < budget) begin
      @(negedge clk_tx);
      k++;
    end
    chk("hs_timeout", (hs_chan.size() >= n), 1);
  endtask

  task automatic clear_log();
    hs_chan.delete();
    hs_data.delete();
    hs_cyc.delete();
  endtask

`ifdef TX_PARITY_EN
  task automatic parity_case(input int c, input logic [DATA_W-1:0] d, input logic exp_p);
    lk.parallel_ready_in = 1'b1;
    lk.wr_en = 4'(1 << c);
    set_word(c, d);
    @(negedge clk_tx);
    lk.wr_en = '0;
    @(negedge clk_tx);
    chk("par_valid", lk.parallel_valid_out, 1);
    chk("par_bit", lk.parallel_parity_out, exp_p);
    @(negedge clk_tx);
  endtask
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n1;
    rst_tx_n = 1'b0;
    lk.wr_en = '0;
    lk.data_in = '0;
    lk.parallel_ready_in = 1'b0;
    @(posedge clk_tx);
    cmp_en = 1'b1;
    do_reset();

    // latency: one word on channel 2, ready held high
    lk.parallel_ready_in = 1'b1;
    lk.wr_en = 4'b0100;
    set_word(2, 16'hAAAA);
    @(negedge clk_tx);
    lk.wr_en = '0;
    @(negedge clk_tx);
    chk("lat_valid", lk.parallel_valid_out, 1);
    chk("lat_data", lk.parallel_data_out, 16'hAAAA);
    chk("lat_chan", lk.parallel_chan_out, 2);
    @(negedge clk_tx);
    chk("lat_drop", lk.parallel_valid_out, 0);

    // fairness: 3 words per channel preloaded under backpressure
    do_reset();
    lk.parallel_ready_in = 1'b0;
    clear_log();
    for (int w = 0; w < 3; w++) begin
      lk.wr_en = 4'hF;
      for (int c = 0; c < NUM_CH; c++) set_word(c, 16'hC000 | 16'(c << 8) | 16'(w));
      @(negedge clk_tx);
    end
    lk.wr_en = '0;
    @(negedge clk_tx);
    lk.parallel_ready_in = 1'b1;
    wait_hs(12, 40);
    for (int i = 0; i < 12 && i < hs_chan.size(); i++) begin
      chk("rr_chan", hs_chan[i], i % 4);
      chk("rr_data", hs_data[i], 16'hC000 | 16'((i % 4) << 8) | 16'(i / 4));
      chk("rr_cycle", hs_cyc[i] - hs_cyc[0], i);
    end

    // backpressure: held word stays put for 5 cycles
    do_reset();
    lk.parallel_ready_in = 1'b0;
    clear_log();
    lk.wr_en = 4'b1000;
    set_word(3, 16'h1234);
    @(negedge clk_tx);
    lk.wr_en = '0;
    @(negedge clk_tx);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", lk.parallel_valid_out, 1);
      chk("bp_data", lk.parallel_data_out, 16'h1234);
      chk("bp_chan", lk.parallel_chan_out, 3);
      @(negedge clk_tx);
    end
    lk.parallel_ready_in = 1'b1;
    @(negedge clk_tx);
    chk("bp_hs_count", hs_chan.size(), 1);
    chk("bp_after", lk.parallel_valid_out, 0);

    // overflow: holding register busy with channel 0, then DEPTH+1 writes to channel 1
    do_reset();
    lk.parallel_ready_in = 1'b0;
    clear_log();
    lk.wr_en = 4'b0001;
    set_word(0, 16'h0F00);
    @(negedge clk_tx);
    lk.wr_en = '0;
    @(negedge clk_tx);
    for (int w = 0; w < DEPTH + 1; w++) begin
      lk.wr_en = 4'b0010;
      set_word(1, 16'h1100 + 16'(w));
      @(negedge clk_tx);
      if (w == DEPTH - 1) begin
        chk("ovf_full_at_8", lk.fifo_full[1], 1);
        chk("ovf_not_yet", lk.overflow[1], 0);
      end
    end
    lk.wr_en = '0;
    chk("ovf_flag", lk.overflow, 4'b0010);
    lk.parallel_ready_in = 1'b1;
    wait_hs(DEPTH + 1, 40);
    for (int i = 0; i < 4; i++) @(negedge clk_tx);
    chk("ovf_total", hs_chan.size(), DEPTH + 1);
    chk("ovf_sticky", lk.overflow, 4'b0010);
    if (hs_chan.size() > 0) begin
      chk("ovf_first_chan", hs_chan[0], 0);
      chk("ovf_first_data", hs_data[0], 16'h0F00);
    end
    n1 = 0;
    for (int i = 0; i < hs_chan.size(); i++) begin
      if (hs_chan[i] == 1) begin
        chk("ovf_order", hs_data[i], 16'h1100 + 16'(n1));
        n1++;
      end
    end
    chk("ovf_ch1_count", n1, DEPTH);

`ifdef TX_PARITY_EN
    do_reset();
    parity_case(0, 16'h0001, 1'b1);
    parity_case(1, 16'h0003, 1'b1);
    parity_case(0, 16'h0003, 1'b0);
`endif

    @(negedge clk_tx);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/par_link_tx_arb.md
# par_link_tx_arb

Multi-channel transmitter for the FPGA-to-FPGA parallel link. It generalises the single-FIFO transmitter to NUM_CH independent input FIFOs of parametrised width and depth, and adds round-robin arbitration, a channel-ID sideband, per-channel overflow flags and optional link parity. It sits in the clk_tx domain and drives the same valid/ready parallel interface that the receiver consumes.

## Interface
- DATA_W, 16, payload width per word
- DEPTH, 8, words per channel FIFO; power of two, at least 2
- NUM_CH, 4, number of input channels, at least 2
- CH_W, $clog2(NUM_CH), channel-ID width (derived)
- clk_tx  in  1  sole clock; all logic is on the rising edge
- rst_tx_n  in  1  reset, synchronous, active-low
- data_in  in  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- wr_en  in  NUM_CH  per-channel write strobe
- fifo_full  out  NUM_CH  channel FIFO holds DEPTH words
- fifo_empty  out  NUM_CH  channel FIFO holds 0 words
- overflow  out  NUM_CH  sticky; set when wr_en is asserted while fifo_full
- parallel_data_out  out  DATA_W  link payload
- parallel_chan_out  out  CH_W  source channel of the link word
- parallel_valid_out  out  1  link word valid
- parallel_ready_in  in  1  receiver accepts the word
- parallel_parity_out  out  1  present only with TX_PARITY_EN

## Operation
- Channel FIFO write: the word is accepted when wr_en[c] && !fifo_full[c]. When fifo_full[c] is high, the write is dropped and overflow[c] is set. A pop in the same cycle does not make room for that write.
- fifo_full and fifo_empty are derived from registered counts (0..DEPTH). Pointers wrap modulo DEPTH. Write and pop on the same channel in the same cycle are both allowed, and the count does not change.
- The output stage is a single holding register with two states:
  - IDLE: parallel_valid_out=0. If any channel is non-empty, pop the granted channel, load the register, and go to SEND.
  - SEND: parallel_valid_out=1. Data, channel and parity are held stable until parallel_ready_in=1.
  - On the handshake in SEND: if any channel is non-empty, pop and reload in the same cycle and stay in SEND. Otherwise go to IDLE.
- Arbitration is round-robin over non-empty channels, starting at (last_grant+1) mod NUM_CH. last_grant updates only on a pop. It resets to NUM_CH-1, so channel 0 has first priority.
- Word order within a channel is preserved. No word is duplicated. The only lost words are the dropped overflow writes.
- overflow[c] clears only on reset.

## Timing
- Reset (rst_tx_n=0 at an edge) sets: parallel_valid_out=0, parallel_data_out=0, parallel_chan_out=0, parallel_parity_out=0, fifo_empty=all 1, fifo_full=0, overflow=0, FIFO counts=0, last_grant=NUM_CH-1, state IDLE.
- Reset mid-transfer discards all FIFO contents and any held word, with no handshake completed.
- Latency: a word written at edge k into an empty system appears with parallel_valid_out=1 after edge k+1.
- Throughput: 1 word per clk_tx cycle while parallel_ready_in=1 and data is available.
- The handshake completes on a rising edge where parallel_valid_out && parallel_ready_in.
- parallel_valid_out never drops without a handshake or reset.
- parallel_ready_in may toggle freely, and no output combinationally depends on it.
- fifo_full[c] rises the edge after the DEPTH-th accepted write. It falls the edge after a pop.

## Configuration
- TX_PARITY_EN defined: parallel_parity_out = even parity over {parallel_chan_out, parallel_data_out}. It is registered together with the data and held with it.
- TX_PARITY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_tx_n=0 for 3 edges with wr_en toggling -> all outputs at their reset values, no words stored after release.
- Latency: write 16'hAAAA to channel 2 with ready=1 -> after the next edge valid=1, data=16'hAAAA, chan=2. Then valid=0 the following edge.
- Fairness: preload 3 words on each of 4 channels with ready=0, then ready=1 -> chan sequence 0,1,2,3,0,1,2,3,0,1,2,3 on consecutive cycles, each channel's data in write order.
- Backpressure: one word queued, ready=0 for 5 cycles -> valid, data and chan stable for all 5. One handshake occurs when ready=1.
- Overflow: ready=0, write DEPTH+1 words to channel 1 -> fifo_full[1]=1 after the 8th write, overflow[1]=1, and the 9th word is never transmitted. Then drain -> exactly 8 words.
- Parity (TX_PARITY_EN): data=16'h0001, chan=0 -> parity=1. data=16'h0003, chan=1 -> parity=1. data=16'h0003, chan=0 -> parity=0.
